bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter that sits directly downstream of the 7x7 Wallace multiplier (14-bit product). It converts the product into packed BCD digits for the calculator's seven-segment display driver. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, with valid/ready handshakes on both sides.

Parameters:
BIN_W, 14, width of the binary input (multiplier product width).
DIGITS, 5, number of BCD digits out; must satisfy 10^DIGITS > 2^BIN_W - 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  bin_in holds a value to convert.
in_ready  output  1  block can accept a new value (IDLE only).
bin_in  input  BIN_W  unsigned binary operand (multiplier product p).
out_valid  output  1  bcd_out holds a finished result.
out_ready  input  1  consumer accepts the result.
bcd_out  output  4*DIGITS  packed BCD; digit i occupies bits [4i+3:4i], digit 0 is least significant.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (async, while rst_n=0): state=IDLE, in_ready=1, out_valid=0, bcd_out=0, counter=0, working registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: load shift register <= bin_in, BCD accumulator <= 0, cnt <= 0, go to SHIFT.
- SHIFT:
  - in_ready=0; in_valid is ignored.
  - Each edge, for every digit: if digit >= 5, add 3 (4-bit, no carry out of the digit).
  - Then shift {accumulator, shift register} left by 1; the shift register MSB enters accumulator bit 0.
  - cnt increments each edge. On the edge where cnt == BIN_W-1 (the BIN_W-th shift):
    - bcd_out <= corrected and shifted accumulator;
    - out_valid <= 1;
    - go to DONE.
- DONE:
  - in_ready=0; out_valid=1; bcd_out held stable.
  - On out_ready=1 at an edge: out_valid <= 0, go to IDLE.
  - A new input cannot be accepted on that same edge (in_ready was 0).
- Latency: out_valid rises exactly BIN_W edges after the accepting edge (14 by default).
  - Minimum initiation interval is BIN_W+2 cycles when out_ready is held at 1.
- bcd_out updates only on entry to DONE and otherwise holds its last value, including across IDLE and SHIFT.
- Counter width: $clog2(BIN_W) bits, minimum 1.
- Arithmetic: every intermediate digit is <= 9 after shifting, given the DIGITS constraint. The top digit never overflows for any input in [0, 2^BIN_W-1].
- Boundary conditions:
  - bin_in=0 yields all-zero BCD.
  - Maximum input 2^BIN_W-1 = 16383 yields 0x16383.
  - out_ready held high in IDLE or SHIFT has no effect.
  - in_valid toggling during SHIFT or DONE has no effect, and bin_in is not resampled.
- Reset mid-operation: rst_n low in any state aborts immediately to the reset values. No partial result is ever presented.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid are decoded from registered state.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - default BIN_W=14 and DIGITS=5;
  - constant ADD3_THRESH=4'd5.
- One sub-module: bcd_add3, a purely combinational 4-bit digit corrector (out = in>=5 ? in+3 : in). It is instantiated DIGITS times via generate.
- Everything else lives in bin2bcd_seq.

Test Plan:
- Reset, then bin_in=0 with in_valid=1 for one cycle -> out_valid rises 14 edges later, bcd_out=0x00000.
- bin_in=9801 (99*99), out_ready=1 -> bcd_out=0x09801. out_valid is high for exactly one cycle; in_ready returns to 1 the following cycle.
- bin_in=16383 -> bcd_out=0x16383. Separately, bin_in=127 -> 0x00127 and bin_in=10 -> 0x00010.
- Backpressure: convert 4096 with out_ready=0 for 20 cycles -> out_valid stays 1 and bcd_out stays 0x04096 throughout. Raise out_ready -> out_valid drops next edge.
- Busy rejection: accept 1234, then drive in_valid=1 with bin_in=5555 during SHIFT -> result is 0x01234, and in_ready=0 for all SHIFT and DONE cycles.
- Async reset: assert rst_n=0 mid-way through the 7th shift of 8191 -> outputs immediately return to reset values. A later conversion of 42 yields 0x00042 with correct 14-cycle latency.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding, default sizes and digit-correction threshold
package bin2bcd_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
  localparam int BIN_W_DEF = 14;
  localparam int DIGITS_DEF = 5;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3: combinational double-dabble digit corrector
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= ADD3_THRESH) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble binary to packed BCD with valid/ready
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out
);
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int ZW = 4*DIGITS + BIN_W;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [ZW-1:0] z, z_sh;
  logic [4*DIGITS-1:0] corr;
  logic last;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_add3 u_add3 (.d(z[BIN_W+4*i +: 4]), .q(corr[4*i +: 4]));
  end
  // accumulator sits above the shift register so one shift moves the operand MSB into digit 0
  assign z_sh = {corr, z[BIN_W-1:0]} << 1;
  assign last = (cnt == CW'(BIN_W-1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE && in_valid) ? SHIFT :
               (state == SHIFT && last) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_comb begin
    in_ready = (state == IDLE);
    out_valid = (state == DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= '0;
      cnt <= '0;
      bcd_out <= '0;
    end else if (state == IDLE && in_valid) begin
      z <= {{(4*DIGITS){1'b0}}, bin_in};
      cnt <= '0;
    end else if (state == SHIFT) begin
      z <= z_sh;
      cnt <= cnt + CW'(1);
      if (last) bcd_out <= z_sh[ZW-1 -: 4*DIGITS];
    end
  end
endmodule
